apb_xfer_sched: RTL

Sequencing controller for the bridge's APB master port. Accepts independent write and read requests from the AXI4-Lite side and arbitrates between them round-robin. Drives the APB SETUP/ACCESS protocol through the APB master signal set (pselx, penable, pwrite, paddr, pwdata, pstrb, pprot) and returns completion, error and read data to the winning requester. Adds a programmable ACCESS-phase timeout so a hung slave cannot stall the bridge.

---
 rtl/apb_bridge_pkg.sv | 26 ++
 rtl/apb_rr_arb2.sv | 27 ++
 rtl/apb_xfer_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types for the AXI4-Lite to APB bridge: sequencer states and the
// granted-request payload carried from the arbiter side to the APB port.
package apb_bridge_pkg;

  localparam int unsigned REQ_AW = 32;
  localparam int unsigned REQ_DW = 32;
  localparam int unsigned REQ_SW = REQ_DW / 8;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } xferState_t;

  typedef struct packed {
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] data;
    logic [REQ_SW-1:0] strb;
    logic [2:0]        prot;
    logic              write;
  } xferReq_t;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way write/read round-robin arbiter; the last-grant register only moves
// when a grant is actually issued (en high and a request present).
module apb_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic wrReq,
  input  logic rdReq,
  output logic grantValid_c,
  output logic grantWrite_c
);

  logic lastWasWrite;

  assign grantValid_c = en && (wrReq || rdReq);
  // On contention the side that did not win last time goes first.
  assign grantWrite_c = wrReq && (!rdReq || !lastWasWrite);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastWasWrite <= 1'b1;
    end else if (grantValid_c) begin
      lastWasWrite <= grantWrite_c;
    end
  end

endmodule

// File: rtl/apb_xfer_sched.sv
// APB master sequencer: arbitrates write/read requests, runs SETUP/ACCESS,
// aborts a hung ACCESS after TIMEOUT cycles and reports completion per side.
module apb_xfer_sched
  import apb_bridge_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   wr_req,
  input  logic [ADDRWIDTH-1:0]   wr_addr,
  input  logic [DATAWIDTH-1:0]   wr_data,
  input  logic [DATAWIDTH/8-1:0] wr_strb,
  input  logic [2:0]             wr_prot,
  output logic                   wr_done,
  output logic                   wr_err,
  input  logic                   rd_req,
  input  logic [ADDRWIDTH-1:0]   rd_addr,
  input  logic [2:0]             rd_prot,
  output logic                   rd_done,
  output logic [DATAWIDTH-1:0]   rd_data,
  output logic                   rd_err,
  output logic                   pselx,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDRWIDTH-1:0]   paddr,
  output logic [DATAWIDTH-1:0]   pwdata,
  output logic [DATAWIDTH/8-1:0] pstrb,
  output logic [2:0]             pprot,
  input  logic                   pready,
  input  logic                   pslverr,
  input  logic [DATAWIDTH-1:0]   prdata
);

  localparam int unsigned SW  = DATAWIDTH / 8;
  localparam int unsigned TOW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TOW-1:0] TO_LAST = TOW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  xferState_t state, stateNxt;
  xferReq_t   req;
  logic       grantValid_c, grantWrite_c, timeoutHit_c;
  logic [TOW-1:0] toCnt, toCntNxt;

  logic                 pselxNxt, penableNxt, pwriteNxt;
  logic [ADDRWIDTH-1:0] paddrNxt;
  logic [DATAWIDTH-1:0] pwdataNxt, rdDataNxt;
  logic [SW-1:0]        pstrbNxt;
  logic [2:0]           pprotNxt;
  logic                 wrDoneNxt, wrErrNxt, rdDoneNxt, rdErrNxt;

  apb_rr_arb2 u_arb (
    .clk          (pclk),
    .rst_n        (presetn),
    .en           (state == IDLE),
    .wrReq        (wr_req),
    .rdReq        (rd_req),
    .grantValid_c (grantValid_c),
    .grantWrite_c (grantWrite_c)
  );

  // Winning payload; reads carry zero data and strobes onto the bus.
  always_comb begin
    req      = '0;
    req.prot = PROT_DEFAULT;
    if (grantWrite_c) begin
      req.write = 1'b1;
      req.addr  = REQ_AW'(wr_addr);
      req.data  = REQ_DW'(wr_data);
      req.strb  = REQ_SW'(wr_strb);
      req.prot  = wr_prot;
    end else begin
      req.addr  = REQ_AW'(rd_addr);
      req.prot  = rd_prot;
    end
  end

  assign timeoutHit_c = (TIMEOUT != 0) && (toCnt == TO_LAST);

  // State and registered outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      toCnt   <= '0;
      pselx   <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
      rd_data <= '0;
    end else begin
      state   <= stateNxt;
      toCnt   <= toCntNxt;
      pselx   <= pselxNxt;
      penable <= penableNxt;
      pwrite  <= pwriteNxt;
      paddr   <= paddrNxt;
      pwdata  <= pwdataNxt;
      pstrb   <= pstrbNxt;
      pprot   <= pprotNxt;
      wr_done <= wrDoneNxt;
      wr_err  <= wrErrNxt;
      rd_done <= rdDoneNxt;
      rd_err  <= rdErrNxt;
      rd_data <= rdDataNxt;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (grantValid_c) stateNxt = SETUP;
      SETUP:   stateNxt = ACCESS;
      ACCESS:  if (pready || timeoutHit_c) stateNxt = RESP;
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; idle bus fields hold their last value.
  always_comb begin
    pselxNxt   = 1'b0;
    penableNxt = 1'b0;
    pwriteNxt  = pwrite;
    paddrNxt   = paddr;
    pwdataNxt  = pwdata;
    pstrbNxt   = pstrb;
    pprotNxt   = pprot;
    wrDoneNxt  = 1'b0;
    wrErrNxt   = 1'b0;
    rdDoneNxt  = 1'b0;
    rdErrNxt   = 1'b0;
    rdDataNxt  = rd_data;
    toCntNxt   = '0;
    case (state)
      IDLE: begin
        if (grantValid_c) begin
          pselxNxt  = 1'b1;
          pwriteNxt = req.write;
          paddrNxt  = ADDRWIDTH'(req.addr);
          pwdataNxt = DATAWIDTH'(req.data);
          pstrbNxt  = SW'(req.strb);
          pprotNxt  = req.prot;
        end
      end
      SETUP: begin
        pselxNxt   = 1'b1;
        penableNxt = 1'b1;
      end
      ACCESS: begin
        // pready takes priority over an abort in the same cycle.
        if (pready) begin
          wrDoneNxt = pwrite;
          wrErrNxt  = pwrite && pslverr;
          rdDoneNxt = !pwrite;
          rdErrNxt  = !pwrite && pslverr;
          if (!pwrite) rdDataNxt = prdata;
        end else if (timeoutHit_c) begin
          wrDoneNxt = pwrite;
          wrErrNxt  = pwrite;
          rdDoneNxt = !pwrite;
          rdErrNxt  = !pwrite;
          if (!pwrite) rdDataNxt = '0;
        end else begin
          pselxNxt   = 1'b1;
          penableNxt = 1'b1;
          toCntNxt   = toCnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
